// File: rtl/loader_defs.sv
// loader_defs: shared definitions for the boot-time program loader.
//   state_t : loader FSM state encoding (3 bits, LEN_HI=0 .. ERR=5)
//   WORD_W  : instruction word width
//   HDR_LEN : header length in bytes (16-bit word count, MSB first)
package loader_defs;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam int WORD_W  = 32;
    localparam int HDR_LEN = 2;

endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: packs four bytes, MSB first, into one 32-bit word.
// Ports:
//   clk   in  : clock, rising edge
//   rst   in  : synchronous active-low reset
//   clr   in  : restart at byte 0 of a new word
//   shift in  : shift din into the low byte
//   din   in  : byte to shift in
//   word  out : assembled word including this cycle's shift
//   full  out : high on the shift that completes a word
module byte_assembler
    import loader_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic [7:0]        din,
    output logic [WORD_W-1:0] word,
    output logic              full
);

    logic [1:0]        r_idx;
    logic [WORD_W-1:0] r_word;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx  <= 2'd0;
            r_word <= '0;
        end else if (clr) begin
            r_idx  <= 2'd0;
        end else if (shift) begin
            r_word <= {r_word[WORD_W-9:0], din};
            r_idx  <= r_idx + 2'd1;
        end
    end

    // The word is presented with the incoming byte already merged, so the
    // caller can capture a complete word on the same edge that full is seen.
    assign word = shift ? {r_word[WORD_W-9:0], din} : r_word;
    assign full = shift && (r_idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader. Receives a byte stream (16-bit word count N,
// then N big-endian 32-bit words) and writes it into instruction memory,
// holding the core in reset until the image is complete.
// Ports:
//   clk, rst         : clock; synchronous active-low reset
//   rx_data/rx_valid : byte stream from the UART receiver
//   rx_ready         : byte accepted this cycle when rx_valid is also high
//   reload           : restart loading; honoured only in DONE or ERR
//   imem_we/addr/wdata : one-cycle word write into instruction memory
//   cpu_hold         : 1 keeps the core in reset (glue combines it with rst)
//   load_done        : image written, core running
//   load_err         : header rejected (N==0 or N larger than memory)
//   word_cnt         : words written so far
module prog_loader
    import loader_defs::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       word_cnt
);

    // 17 bits so that N == 2**ADDR_W (a completely full memory) is legal.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            r_state;
    logic [15:0]       r_n;
    logic [15:0]       r_word_idx;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [WORD_W-1:0] r_imem_wdata;
    logic              r_cpu_hold;
    logic              r_load_done;
    logic              r_load_err;
    logic [15:0]       r_word_cnt;

    logic              w_accept;
    logic              w_shift;
    logic              w_clr;
    logic              w_reload;
    logic              w_full;
    logic [WORD_W-1:0] w_word;
    logic [15:0]       w_n;
    logic              w_n_bad;

    // rx_ready depends only on the state register, never on rx_valid.
    assign rx_ready = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                      (r_state == ST_DATA);
    assign w_accept = rx_valid && rx_ready;
    assign w_shift  = w_accept && (r_state == ST_DATA);
    assign w_reload = reload && ((r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_clr    = (w_accept && (r_state == ST_LEN_LO)) ||
                      (r_state == ST_WRITE) || w_reload;
    assign w_n      = {r_n[15:8], rx_data};
    assign w_n_bad  = (w_n == 16'd0) || ({1'b0, w_n} > MAX_WORDS);

    byte_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .shift (w_shift),
        .din   (rx_data),
        .word  (w_word),
        .full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_LEN_HI;
            r_n          <= 16'd0;
            r_word_idx   <= 16'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_hold   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_word_cnt   <= 16'd0;
        end else begin
            case (r_state)
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_n[15:8] <= rx_data;
                        r_state   <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_n <= w_n;
                        if (w_n_bad) begin
                            r_load_err <= 1'b1;
                            r_state    <= ST_ERR;
                        end else begin
                            r_word_idx <= 16'd0;
                            r_state    <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Write strobe and payload are registered here so they
                    // are valid for the whole WRITE cycle.
                    if (w_full) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_idx[ADDR_W-1:0];
                        r_imem_wdata <= w_word;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_imem_we  <= 1'b0;
                    r_word_cnt <= r_word_cnt + 16'd1;
                    if (r_word_idx == r_n - 16'd1) begin
                        r_cpu_hold  <= 1'b0;
                        r_load_done <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_word_idx <= r_word_idx + 16'd1;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (w_reload) begin
                        r_n         <= 16'd0;
                        r_word_idx  <= 16'd0;
                        r_word_cnt  <= 16'd0;
                        r_load_done <= 1'b0;
                        r_load_err  <= 1'b0;
                        r_cpu_hold  <= 1'b1;
                        r_state     <= ST_LEN_HI;
                    end
                end
                default: r_state <= ST_LEN_HI;
            endcase
        end
    end

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed sequence with randomized payloads and gaps,
// checked against an image-level reference model (header -> list of writes).
module tb_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [15:0]       word_cnt;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  img[$];
    int unsigned mon_addr[$];
    logic [31:0] mon_data[$];
    int          bad_accept = 0;

    // Observed writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            mon_addr.push_back(int'(imem_addr));
            mon_data.push_back(imem_wdata);
            if (rx_valid && rx_ready) bad_accept++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        bad_accept = 0;
    endtask

    task automatic build_image(input int n_hdr, input int n_words);
        img.delete();
        img.push_back(8'((n_hdr >> 8) & 8'hFF));
        img.push_back(8'(n_hdr & 8'hFF));
        for (int i = 0; i < 4 * n_words; i++) img.push_back(8'($urandom_range(255, 0)));
    endtask

    function automatic int hdr_n();
        return (int'(img[0]) << 8) | int'(img[1]);
    endfunction

    function automatic bit hdr_legal();
        return (hdr_n() != 0) && (hdr_n() <= (1 << ADDR_W));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rx_ready) begin
            check("accept_timeout", 32'(rx_ready), 32'd1);
            return;
        end
        @(posedge clk); #1;
    endtask

    // Sends bytes [from, to) of the current image.
    task automatic send_range(input int from, input int to, input int gap_max);
        for (int i = from; i < to; i++)
            send_byte(img[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
    endtask

    task automatic run_image(input int gap_max);
        send_range(0, hdr_legal() ? img.size() : 2, gap_max);
        rx_valid = 1'b0;
        for (int t = 0; t < 20 && !(load_done || load_err); t++) begin
            @(posedge clk); #1;
        end
    endtask

    // Reference: every word i of a legal image lands at i mod 2**ADDR_W.
    task automatic compare_writes(input string tag);
        int n, exp_cnt, mism;
        logic [31:0] w;
        n       = hdr_n();
        exp_cnt = hdr_legal() ? n : 0;
        check({tag, "/nwrites"}, 32'(mon_addr.size()), 32'(exp_cnt));
        mism = 0;
        for (int i = 0; i < exp_cnt && i < mon_addr.size(); i++) begin
            w = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
            if (mon_addr[i] != (i % (1 << ADDR_W)) || mon_data[i] !== w) mism++;
        end
        check({tag, "/mismatches"}, 32'(mism), 32'd0);
        check({tag, "/load_done"}, 32'(load_done), 32'(hdr_legal()));
        check({tag, "/load_err"}, 32'(load_err), 32'(!hdr_legal()));
        check({tag, "/cpu_hold"}, 32'(cpu_hold), 32'(!hdr_legal()));
        check({tag, "/word_cnt"}, 32'(word_cnt), 32'(exp_cnt));
        check({tag, "/accept_in_write"}, 32'(bad_accept), 32'd0);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "/imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "/imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "/imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "/cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "/load_done"}, 32'(load_done), 32'd0);
        check({tag, "/load_err"}, 32'(load_err), 32'd0);
        check({tag, "/word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    initial begin
        logic [7:0] basic[10];
        int unsigned last;

        rst = 1'b0; reload = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;

        // Basic load with rx_valid held constant, plus exact release timing.
        basic = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};
        img.delete();
        foreach (basic[i]) img.push_back(basic[i]);
        clear_mon();
        send_range(0, img.size(), 0);
        check("basic/we_in_write", 32'(imem_we), 32'd1);
        check("basic/addr_in_write", 32'(imem_addr), 32'd1);
        check("basic/wdata_in_write", imem_wdata, 32'h0800_0000);
        check("basic/hold_in_write", 32'(cpu_hold), 32'd1);
        check("basic/ready_in_write", 32'(rx_ready), 32'd0);
        @(posedge clk); #1;
        check("basic/hold_released", 32'(cpu_hold), 32'd0);
        check("basic/done_rises", 32'(load_done), 32'd1);
        // Bytes offered in DONE must be ignored.
        rx_valid = 1'b1; rx_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check("done/ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
        compare_writes("basic");

        // Reload after DONE, then a single DEADBEEF word.
        pulse_reload();
        check("reload/cpu_hold", 32'(cpu_hold), 32'd1);
        check("reload/load_done", 32'(load_done), 32'd0);
        check("reload/word_cnt", 32'(word_cnt), 32'd0);
        check("reload/rx_ready", 32'(rx_ready), 32'd1);
        img.delete();
        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_mon();
        run_image(0);
        compare_writes("deadbeef");

        // Header errors: N=0 and N=2**ADDR_W+1.
        pulse_reload();
        build_image(0, 0);
        clear_mon();
        run_image(0);
        rx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("n0/ready_in_err", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
        compare_writes("n0");

        pulse_reload();
        check("reload_err/load_err", 32'(load_err), 32'd0);
        build_image(16'h0401, 0);
        clear_mon();
        run_image(0);
        compare_writes("n401");

        // Random images with random idle gaps between bytes.
        for (int r = 0; r < 3; r++) begin
            pulse_reload();
            build_image(int'($urandom_range(8, 1)), 0);
            for (int i = 0; i < 4 * hdr_n(); i++) img.push_back(8'($urandom_range(255, 0)));
            clear_mon();
            run_image(7);
            compare_writes($sformatf("gaps%0d", r));
        end

        // Reload pulsed during DATA has no effect.
        pulse_reload();
        build_image(2, 2);
        clear_mon();
        send_range(0, 4, 0);
        rx_valid = 1'b0;
        pulse_reload();
        check("reload_in_data/ready", 32'(rx_ready), 32'd1);
        send_range(4, img.size(), 0);
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_writes("reload_in_data");

        // Reset after 5 data bytes, then a fresh N=1 image.
        pulse_reload();
        build_image(2, 2);
        send_range(0, 7, 0);
        rx_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset("midreset");
        rst = 1'b1;
        build_image(1, 1);
        clear_mon();
        run_image(0);
        compare_writes("after_reset");

        // Full memory: N = 2**ADDR_W is legal; last write at the top address.
        pulse_reload();
        build_image(1 << ADDR_W, 1 << ADDR_W);
        clear_mon();
        run_image(0);
        compare_writes("n1024");
        last = (mon_addr.size() == 0) ? 0 : mon_addr[mon_addr.size() - 1];
        check("n1024/last_addr", last, 32'h3FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
